// File: rtl/rv_decode_exec_unit_if.sv
// rtl/rv_decode_exec_unit_if.sv - request/result bundle for the RV32 decode/execute slice
//
// Purpose: carries the fetched instruction with its two register operands
// towards the slice, and the registered decode/control/ALU results back out.
// Ports (signals):
//   in_valid, instr[31:0], rs1_data[31:0], rs2_data[31:0]   producer -> slice
//   out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm,
//   reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch,
//   alu_ctrl[3:0], alu_result[31:0], zero, take_branch       slice -> consumer
// Modports: master = producer/consumer side, slave = the slice itself.

interface rv_decode_exec_unit_if;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        out_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        reg_write;
  logic        alu_src;
  logic        mem_write;
  logic        mem_read;
  logic        mem_to_reg;
  logic        branch;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic        take_branch;

  modport master (
    output in_valid, instr, rs1_data, rs2_data,
    input  out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm,
           reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch,
           alu_ctrl, alu_result, zero, take_branch
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data,
    output out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm,
           reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch,
           alu_ctrl, alu_result, zero, take_branch
  );
endinterface

// File: rtl/rv_decode_exec_unit.sv
// rtl/rv_decode_exec_unit.sv - single-stage RV32 decode, control, immediate and ALU slice
//
// Purpose: decodes one instruction per cycle, generates its immediate and
// control strobes, runs the 32-bit ALU and the branch compare, and registers
// all results (1-cycle latency).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset; clears every output
//   bus    rv_decode_exec_unit_if.slave (inputs: in_valid/instr/rs1_data/
//          rs2_data; outputs: decoded fields, strobes, alu_ctrl, alu_result,
//          zero, take_branch, out_valid)

module rv_decode_exec_unit (
  input  logic                   clk,
  input  logic                   reset,
  rv_decode_exec_unit_if.slave   bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic [6:0]  op_c;
  logic [2:0]  f3_c;
  logic [6:0]  f7_c;
  logic [31:0] imm_c;
  logic        reg_write_c;
  logic        alu_src_c;
  logic        mem_write_c;
  logic        mem_read_c;
  logic        mem_to_reg_c;
  logic        branch_c;
  logic [3:0]  alu_ctrl_c;
  logic [31:0] operand_b_c;
  logic [31:0] result_c;
  logic        zero_c;

  assign op_c = bus.instr[6:0];
  assign f3_c = bus.instr[14:12];
  assign f7_c = bus.instr[31:25];

  // Immediate generation. B and J immediates stay in halfword units; the PC
  // adder downstream applies the final shift.
  always_comb begin
    imm_c = 32'd0;
    case (op_c)
      OP_IMM, OP_LOAD, OP_JALR:
        imm_c = {{20{bus.instr[31]}}, bus.instr[31:20]};
      OP_STORE:
        imm_c = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      OP_BRANCH:
        imm_c = {{20{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                 bus.instr[30:25], bus.instr[11:8]};
      OP_LUI, OP_AUIPC:
        imm_c = {bus.instr[31:12], 12'd0};
      OP_JAL:
        imm_c = {{12{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                 bus.instr[20], bus.instr[30:21]};
      default:
        imm_c = 32'd0;
    endcase
  end

  // Main control decode.
  always_comb begin
    reg_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    branch_c     = 1'b0;
    case (op_c)
      OP_R: begin
        reg_write_c = 1'b1;
      end
      OP_IMM: begin
        reg_write_c = 1'b1;
        alu_src_c   = 1'b1;
      end
      OP_LOAD: begin
        reg_write_c  = 1'b1;
        alu_src_c    = 1'b1;
        mem_read_c   = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      OP_STORE: begin
        alu_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      OP_BRANCH: begin
        branch_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ALU-control mapping. OP-IMM shares the R-type funct3 table except that
  // funct7 never selects SUB (there is no subtract-immediate).
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (op_c)
      OP_LOAD, OP_STORE: alu_ctrl_c = ALU_ADD;
      OP_BRANCH:         alu_ctrl_c = ALU_SUB;
      OP_R, OP_IMM: begin
        case (f3_c)
          3'b000:  alu_ctrl_c = (op_c == OP_R && f7_c == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b100:  alu_ctrl_c = ALU_XOR;
          3'b110:  alu_ctrl_c = ALU_OR;
          3'b111:  alu_ctrl_c = ALU_AND;
          default: alu_ctrl_c = ALU_ADD;
        endcase
      end
      default: alu_ctrl_c = ALU_ADD;
    endcase
  end

  assign operand_b_c = alu_src_c ? imm_c : bus.rs2_data;

  always_comb begin
    result_c = 32'd0;
    case (alu_ctrl_c)
      ALU_ADD: result_c = bus.rs1_data + operand_b_c;
      ALU_SUB: result_c = bus.rs1_data - operand_b_c;
      ALU_AND: result_c = bus.rs1_data & operand_b_c;
      ALU_OR:  result_c = bus.rs1_data | operand_b_c;
      ALU_XOR: result_c = bus.rs1_data ^ operand_b_c;
      default: result_c = 32'd0;
    endcase
  end

  assign zero_c = (result_c == 32'd0);

  // Output register. A bubble kills only valid and the side-effecting strobes;
  // fields and datapath results hold so downstream sees stable values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_valid   <= 1'b0;
      bus.opcode      <= 7'd0;
      bus.rd          <= 5'd0;
      bus.funct3      <= 3'd0;
      bus.rs1         <= 5'd0;
      bus.rs2         <= 5'd0;
      bus.funct7      <= 7'd0;
      bus.imm         <= 32'd0;
      bus.reg_write   <= 1'b0;
      bus.alu_src     <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_to_reg  <= 1'b0;
      bus.branch      <= 1'b0;
      bus.alu_ctrl    <= 4'd0;
      bus.alu_result  <= 32'd0;
      bus.zero        <= 1'b0;
      bus.take_branch <= 1'b0;
    end else if (bus.in_valid) begin
      bus.out_valid   <= 1'b1;
      bus.opcode      <= op_c;
      bus.rd          <= bus.instr[11:7];
      bus.funct3      <= f3_c;
      bus.rs1         <= bus.instr[19:15];
      bus.rs2         <= bus.instr[24:20];
      bus.funct7      <= f7_c;
      bus.imm         <= imm_c;
      bus.reg_write   <= reg_write_c;
      bus.alu_src     <= alu_src_c;
      bus.mem_write   <= mem_write_c;
      bus.mem_read    <= mem_read_c;
      bus.mem_to_reg  <= mem_to_reg_c;
      bus.branch      <= branch_c;
      bus.alu_ctrl    <= alu_ctrl_c;
      bus.alu_result  <= result_c;
      bus.zero        <= zero_c;
      bus.take_branch <= branch_c & zero_c;
    end else begin
      bus.out_valid   <= 1'b0;
      bus.reg_write   <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_to_reg  <= 1'b0;
      bus.branch      <= 1'b0;
      bus.take_branch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_decode_exec_unit.sv
// tb/tb_rv_decode_exec_unit.sv - randomized self-checking bench for rv_decode_exec_unit

module tb_rv_decode_exec_unit;

  typedef struct packed {
    logic        out_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        reg_write;
    logic        alu_src;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        branch;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic        take_branch;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t exp_s;

  rv_decode_exec_unit_if bus ();

  rv_decode_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, want);
    end
  endtask

  // Reference model: field values straight from the instruction word, immediates
  // as signed integers (sign bit carries negative weight), ALU as plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   v;
    logic [31:0] opb;
    logic [31:0] r;
    e = '0;
    v = 0;
    e.out_valid = 1'b1;
    e.opcode    = ins[6:0];
    e.rd        = ins[11:7];
    e.funct3    = ins[14:12];
    e.rs1       = ins[19:15];
    e.rs2       = ins[24:20];
    e.funct7    = ins[31:25];

    case (ins[6:0])
      7'h13, 7'h03, 7'h67: v = int'(ins[30:20]) - int'(ins[31]) * 2048;
      7'h23: v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - int'(ins[31]) * 2048;
      7'h63: v = int'(ins[7]) * 1024 + int'(ins[30:25]) * 16 + int'(ins[11:8])
                 - int'(ins[31]) * 2048;
      7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
      7'h6F: v = int'(ins[19:12]) * 2048 + int'(ins[20]) * 1024 + int'(ins[30:21])
                 - int'(ins[31]) * 524288;
      default: v = 0;
    endcase
    e.imm = 32'(v);

    e.alu_ctrl = 4'd0;
    case (ins[6:0])
      7'h33: e.reg_write = 1'b1;
      7'h13: begin e.reg_write = 1'b1; e.alu_src = 1'b1; end
      7'h03: begin
        e.reg_write = 1'b1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
      end
      7'h23: begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
      7'h63: begin e.branch = 1'b1; e.alu_ctrl = 4'd1; end
      default: ;
    endcase

    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      if (ins[14:12] == 3'd4)      e.alu_ctrl = 4'd4;
      else if (ins[14:12] == 3'd6) e.alu_ctrl = 4'd3;
      else if (ins[14:12] == 3'd7) e.alu_ctrl = 4'd2;
      else if (ins[14:12] == 3'd0 && ins[6:0] == 7'h33 && ins[31:25] == 7'h20)
        e.alu_ctrl = 4'd1;
    end

    opb = e.alu_src ? e.imm : b;
    case (e.alu_ctrl)
      4'd1: r = 32'(longint'(a) - longint'(opb));
      4'd2: r = a & opb;
      4'd3: r = a | opb;
      4'd4: r = a ^ opb;
      default: r = 32'(longint'(a) + longint'(opb));
    endcase
    e.alu_result  = r;
    e.zero        = (r == 32'd0);
    e.take_branch = e.branch && e.zero;
    return e;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".out_valid"},   32'(bus.out_valid),   32'(exp_s.out_valid));
    check_eq({tag, ".opcode"},      32'(bus.opcode),      32'(exp_s.opcode));
    check_eq({tag, ".rd"},          32'(bus.rd),          32'(exp_s.rd));
    check_eq({tag, ".funct3"},      32'(bus.funct3),      32'(exp_s.funct3));
    check_eq({tag, ".rs1"},         32'(bus.rs1),         32'(exp_s.rs1));
    check_eq({tag, ".rs2"},         32'(bus.rs2),         32'(exp_s.rs2));
    check_eq({tag, ".funct7"},      32'(bus.funct7),      32'(exp_s.funct7));
    check_eq({tag, ".imm"},         bus.imm,              exp_s.imm);
    check_eq({tag, ".reg_write"},   32'(bus.reg_write),   32'(exp_s.reg_write));
    check_eq({tag, ".alu_src"},     32'(bus.alu_src),     32'(exp_s.alu_src));
    check_eq({tag, ".mem_write"},   32'(bus.mem_write),   32'(exp_s.mem_write));
    check_eq({tag, ".mem_read"},    32'(bus.mem_read),    32'(exp_s.mem_read));
    check_eq({tag, ".mem_to_reg"},  32'(bus.mem_to_reg),  32'(exp_s.mem_to_reg));
    check_eq({tag, ".branch"},      32'(bus.branch),      32'(exp_s.branch));
    check_eq({tag, ".alu_ctrl"},    32'(bus.alu_ctrl),    32'(exp_s.alu_ctrl));
    check_eq({tag, ".alu_result"},  bus.alu_result,       exp_s.alu_result);
    check_eq({tag, ".zero"},        32'(bus.zero),        32'(exp_s.zero));
    check_eq({tag, ".take_branch"}, 32'(bus.take_branch), 32'(exp_s.take_branch));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input string tag, input logic rst_n, input logic v,
                      input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    reset        = rst_n;
    bus.in_valid = v;
    bus.instr    = ins;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(posedge clk);
    if (!rst_n) begin
      exp_s = '0;
    end else if (v) begin
      exp_s = model(ins, a, b);
    end else begin
      exp_s.out_valid   = 1'b0;
      exp_s.reg_write   = 1'b0;
      exp_s.mem_write   = 1'b0;
      exp_s.mem_read    = 1'b0;
      exp_s.mem_to_reg  = 1'b0;
      exp_s.branch      = 1'b0;
      exp_s.take_branch = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  logic [6:0] op_pool [10];

  initial begin
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    total = 0;
    bad   = 0;
    exp_s = '0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr    = 32'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    op_pool = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h0F};

    step("rst", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step("rst2", 1'b0, 1'b1, 32'h002081B3, 32'd5, 32'd7);

    step("add", 1'b1, 1'b1, 32'h002081B3, 32'd5, 32'd7);
    check_eq("add.result_const", bus.alu_result, 32'd12);
    check_eq("add.rd_const", 32'(bus.rd), 32'd3);
    step("sub", 1'b1, 1'b1, 32'h402081B3, 32'd5, 32'd7);
    check_eq("sub.result_const", bus.alu_result, 32'hFFFF_FFFE);
    check_eq("sub.ctrl_const", 32'(bus.alu_ctrl), 32'd1);
    step("addi", 1'b1, 1'b1, 32'hFFF00093, 32'd0, 32'd0);
    check_eq("addi.imm_const", bus.imm, 32'hFFFF_FFFF);
    step("sw", 1'b1, 1'b1, 32'h0020A423, 32'h100, 32'd0);
    check_eq("sw.result_const", bus.alu_result, 32'h108);
    check_eq("sw.mem_write_const", 32'(bus.mem_write), 32'd1);
    step("beq_t", 1'b1, 1'b1, 32'h00208463, 32'd9, 32'd9);
    check_eq("beq_t.imm_const", bus.imm, 32'd4);
    check_eq("beq_t.take_const", 32'(bus.take_branch), 32'd1);
    step("bubble_keep", 1'b1, 1'b0, 32'h0, 32'd0, 32'd0);
    check_eq("bubble.zero_hold", 32'(bus.zero), 32'd1);
    step("beq_nt", 1'b1, 1'b1, 32'h00208463, 32'd9, 32'd8);
    check_eq("beq_nt.take_const", 32'(bus.take_branch), 32'd0);

    step("rst_mid", 1'b0, 1'b1, 32'h002081B3, 32'd5, 32'd7);
    check_eq("rst_mid.result_const", bus.alu_result, 32'd0);
    step("bubble", 1'b1, 1'b0, 32'h002081B3, 32'd5, 32'd7);
    check_eq("bubble.valid_const", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[6:0] = op_pool[$urandom_range(0, 9)];
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      if ($urandom_range(0, 4) == 0) a = 32'd0;
      step($sformatf("rnd%0d", i), ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 5) != 0), ins, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_exec_unit.md
Name: rv_decode_exec_unit

Overview:
Single-stage RV32 decode/execute slice that combines instruction field decode, immediate generation, main control, ALU-control mapping and a 32-bit ALU. It takes a fetched instruction plus the two register-file read values. It returns, one cycle later, the decoded fields, control strobes, ALU result and branch decision. It sits between instruction fetch / register-file read and the memory / writeback / PC-update logic of the single-cycle core.

Parameters:
None (data width fixed at 32, register index width fixed at 5).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (asserted when 0)
in_valid  in  1  instr/rs1_data/rs2_data are valid this cycle
instr  in  32  instruction word
rs1_data  in  32  register value addressed by instr[19:15]
rs2_data  in  32  register value addressed by instr[24:20]
out_valid  out  1  registered outputs hold a valid result
opcode  out  7  instr[6:0]
rd  out  5  instr[11:7]
funct3  out  3  instr[14:12]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
funct7  out  7  instr[31:25]
imm  out  32  sign-extended immediate
reg_write, alu_src, mem_write, mem_read, mem_to_reg, branch  out  1 each  control strobes
alu_ctrl  out  4  ALU operation code
alu_result  out  32  ALU output
zero  out  1  alu_result == 0
take_branch  out  1  branch & zero

Behaviour:
- Pipeline and reset:
  - All outputs are registered with 1-cycle latency: inputs sampled at edge N appear after edge N.
  - Reset low at a rising edge clears every output to 0, including out_valid, regardless of in_valid. Reset mid-operation discards the in-flight instruction.
- in_valid handling:
  - in_valid=0 at an edge: out_valid<=0; reg_write, mem_write, mem_read, mem_to_reg, branch and take_branch <= 0 (bubble).
  - On a bubble, all other outputs hold their previous values.
  - in_valid=1: all outputs are updated and out_valid<=1.
- Immediate generation, by opcode:
  - I-type (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8]}). This is in halfword units; the PC adder shifts it left 1.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21]}). Halfword units.
  - Any other opcode: 0.
- Control decode (any strobe not listed is 0):
  - R-type 0110011: reg_write.
  - OP-IMM 0010011: reg_write, alu_src.
  - LOAD 0000011: reg_write, alu_src, mem_read, mem_to_reg.
  - STORE 0100011: alu_src, mem_write.
  - BRANCH 1100011: branch, with alu_src=0.
  - All other opcodes: all strobes 0.
- alu_ctrl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
- alu_ctrl selection:
  - LOAD/STORE: ADD.
  - BRANCH: SUB.
  - R-type, funct3 selects the op:
    - 000: SUB if funct7==0100000, else ADD.
    - 100: XOR.
    - 110: OR.
    - 111: AND.
    - Other funct3: ADD.
  - OP-IMM: same funct3 map as R-type, except 000 is always ADD (funct7 ignored).
  - Other opcodes: ADD.
- ALU:
  - Operand a = rs1_data; b = alu_src ? imm : rs2_data.
  - ADD/SUB are modulo 2^32 with no overflow flag.
  - Undefined alu_ctrl codes produce result 0.
  - zero and take_branch are computed from the same-cycle result.

Test Plan:
1. add x3,x1,x2: instr 0x002081B3, rs1_data=5, rs2_data=7 -> next cycle: alu_result=12, rd=3, rs1=1, rs2=2, reg_write=1, alu_src=0, alu_ctrl=0000, out_valid=1.
2. sub x3,x1,x2: instr 0x402081B3, rs1_data=5, rs2_data=7 -> alu_result=0xFFFFFFFE, alu_ctrl=0001, zero=0.
3. addi x1,x0,-1: instr 0xFFF00093, rs1_data=0 -> imm=0xFFFFFFFF, alu_src=1, alu_result=0xFFFFFFFF, reg_write=1.
4. sw x2,8(x1): instr 0x0020A423, rs1_data=0x100 -> imm=8, alu_result=0x108, mem_write=1, reg_write=0, mem_read=0.
5. beq x1,x2,+8: instr 0x00208463.
   - rs1_data=rs2_data=9 -> imm=4, branch=1, alu_ctrl=0001, zero=1, take_branch=1.
   - Repeat with rs2_data=8 -> take_branch=0.
6. Bubble and reset:
   - Hold reset=0 for one edge with in_valid=1 and instr 0x002081B3 -> all outputs 0.
   - Release reset, drive in_valid=0 -> out_valid=0, all strobes 0, alu_result unchanged.
